// File: rtl/branch_resolve_q.sv
// Resolves branch direction/target, raises mispredict redirects and queues PHT/BTB updates.
// Optional statistics counters are enabled by defining BR_STATS_EN.
module branch_resolve_q #(
    parameter int CTR_W     = 2,
    parameter int PHT_IDX_W = 10,
    parameter int BTB_IDX_W = 7,
    parameter int BTB_TAG_W = 22,
    parameter int QDEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 branch_valid_i,
    input  logic [3:0]           branch_type_i,
    input  logic [31:0]          rj_value_i,
    input  logic [31:0]          rkd_value_i,
    input  logic [31:0]          pc_i,
    input  logic [31:0]          br_b_target_i,
    input  logic [31:0]          jirl_offs_i,
    input  logic [CTR_W-1:0]     pht_ctr_i,
    input  logic                 btb_hit_i,
    input  logic                 predict_taken_i,
    input  logic [31:0]          predict_target_i,
    output logic                 branch_ready_o,
    output logic                 branch_taken_o,
    output logic [31:0]          branch_target_o,
    output logic                 branch_flush_o,
    output logic [31:0]          branch_flush_pc_o,
    output logic                 upd_valid_o,
    input  logic                 upd_ready_i,
    output logic                 upd_pht_we_o,
    output logic                 upd_btb_we_o,
    output logic [PHT_IDX_W-1:0] upd_pht_idx_o,
    output logic [CTR_W-1:0]     upd_pht_ctr_o,
    output logic [BTB_IDX_W-1:0] upd_btb_idx_o,
    output logic [BTB_TAG_W-1:0] upd_btb_tag_o,
    output logic [31:0]          upd_btb_target_o,
    output logic [31:0]          branch_cnt_o,
    output logic [31:0]          mispred_cnt_o
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    typedef struct packed {
        logic                 pht_we;
        logic                 btb_we;
        logic [PHT_IDX_W-1:0] pht_idx;
        logic [CTR_W-1:0]     pht_ctr;
        logic [BTB_IDX_W-1:0] btb_idx;
        logic [BTB_TAG_W-1:0] btb_tag;
        logic [31:0]          btb_target;
    } rec_t;

    logic           eq, lt_s, lt_u, taken, valid_type, cond_type;
    logic [31:0]    target;
    logic           pred_taken, tgt_miss, mispredict, accept;
    logic           pht_we, btb_we, push, pop, full;
    logic [CTR_W-1:0] ctr_next;
    rec_t           new_rec, head;
    rec_t           mem [QDEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;

    assign eq   = rj_value_i == rkd_value_i;
    assign lt_s = $signed(rj_value_i) < $signed(rkd_value_i);
    assign lt_u = rj_value_i < rkd_value_i;

    always_comb begin
        taken = 1'b0;
        case (branch_type_i)
            4'd1:             taken = eq;
            4'd2:             taken = !eq;
            4'd3:             taken = lt_s;
            4'd4:             taken = !lt_s;
            4'd5:             taken = lt_u;
            4'd6:             taken = !lt_u;
            4'd7, 4'd8, 4'd9: taken = 1'b1;
            default:          taken = 1'b0;
        endcase
    end

    assign valid_type = (branch_type_i >= 4'd1) && (branch_type_i <= 4'd9);
    assign cond_type  = (branch_type_i >= 4'd1) && (branch_type_i <= 4'd6);
    assign target     = (branch_type_i == 4'd9) ? rj_value_i + jirl_offs_i : br_b_target_i;

    assign pred_taken = predict_taken_i & btb_hit_i;
    assign tgt_miss   = target != predict_target_i;
    assign mispredict = (taken != pred_taken) | (taken & pred_taken & tgt_miss);

    assign full           = count == (PTR_W+1)'(QDEPTH);
    assign pop            = upd_valid_o & upd_ready_i;
    assign branch_ready_o = !full | pop;
    assign accept         = branch_valid_i & branch_ready_o & valid_type;

    assign branch_taken_o    = taken;
    assign branch_target_o   = target;
    assign branch_flush_o    = accept & mispredict;
    assign branch_flush_pc_o = taken ? target : pc_i + 32'd4;

    assign ctr_next = taken ? ((pht_ctr_i == CTR_MAX) ? pht_ctr_i : pht_ctr_i + CTR_W'(1))
                            : ((pht_ctr_i == '0) ? pht_ctr_i : pht_ctr_i - CTR_W'(1));

    assign pht_we = cond_type;
    assign btb_we = taken & (!btb_hit_i | !predict_taken_i | tgt_miss);
    assign push   = accept & (pht_we | btb_we);

    // Fields belonging to a disabled write are stored as zero so the head is fully defined.
    always_comb begin
        new_rec            = '0;
        new_rec.pht_we     = pht_we;
        new_rec.btb_we     = btb_we;
        if (pht_we) begin
            new_rec.pht_idx = pc_i[2 +: PHT_IDX_W];
            new_rec.pht_ctr = ctr_next;
        end
        if (btb_we) begin
            new_rec.btb_idx    = pc_i[2 +: BTB_IDX_W];
            new_rec.btb_tag    = pc_i[2 + BTB_IDX_W +: BTB_TAG_W];
            new_rec.btb_target = target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= new_rec;
    end

    assign upd_valid_o      = count != '0;
    assign head             = upd_valid_o ? mem[rd_ptr] : '0;
    assign upd_pht_we_o     = head.pht_we;
    assign upd_btb_we_o     = head.btb_we;
    assign upd_pht_idx_o    = head.pht_idx;
    assign upd_pht_ctr_o    = head.pht_ctr;
    assign upd_btb_idx_o    = head.btb_idx;
    assign upd_btb_tag_o    = head.btb_tag;
    assign upd_btb_target_o = head.btb_target;

`ifdef BR_STATS_EN
    logic [31:0] branch_cnt, mispred_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (accept && branch_cnt != '1)
                branch_cnt <= branch_cnt + 32'd1;
            if (branch_flush_o && mispred_cnt != '1)
                mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

    assign branch_cnt_o  = branch_cnt;
    assign mispred_cnt_o = mispred_cnt;
`else
    assign branch_cnt_o  = '0;
    assign mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_q.sv
// Randomized + directed bench for branch_resolve_q against a queue-based reference model.
module tb_branch_resolve_q;
    localparam int CTR_W     = 2;
    localparam int PHT_IDX_W = 10;
    localparam int BTB_IDX_W = 7;
    localparam int BTB_TAG_W = 22;
    localparam int QDEPTH    = 4;
    localparam int MAXC      = (1 << CTR_W) - 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 branch_valid_i;
    logic [3:0]           branch_type_i;
    logic [31:0]          rj_value_i, rkd_value_i, pc_i, br_b_target_i, jirl_offs_i;
    logic [CTR_W-1:0]     pht_ctr_i;
    logic                 btb_hit_i, predict_taken_i;
    logic [31:0]          predict_target_i;
    logic                 branch_ready_o, branch_taken_o, branch_flush_o;
    logic [31:0]          branch_target_o, branch_flush_pc_o;
    logic                 upd_valid_o, upd_ready_i, upd_pht_we_o, upd_btb_we_o;
    logic [PHT_IDX_W-1:0] upd_pht_idx_o;
    logic [CTR_W-1:0]     upd_pht_ctr_o;
    logic [BTB_IDX_W-1:0] upd_btb_idx_o;
    logic [BTB_TAG_W-1:0] upd_btb_tag_o;
    logic [31:0]          upd_btb_target_o, branch_cnt_o, mispred_cnt_o;

    branch_resolve_q #(
        .CTR_W(CTR_W), .PHT_IDX_W(PHT_IDX_W), .BTB_IDX_W(BTB_IDX_W),
        .BTB_TAG_W(BTB_TAG_W), .QDEPTH(QDEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .branch_valid_i(branch_valid_i), .branch_type_i(branch_type_i),
        .rj_value_i(rj_value_i), .rkd_value_i(rkd_value_i), .pc_i(pc_i),
        .br_b_target_i(br_b_target_i), .jirl_offs_i(jirl_offs_i),
        .pht_ctr_i(pht_ctr_i), .btb_hit_i(btb_hit_i), .predict_taken_i(predict_taken_i),
        .predict_target_i(predict_target_i),
        .branch_ready_o(branch_ready_o), .branch_taken_o(branch_taken_o),
        .branch_target_o(branch_target_o), .branch_flush_o(branch_flush_o),
        .branch_flush_pc_o(branch_flush_pc_o),
        .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i),
        .upd_pht_we_o(upd_pht_we_o), .upd_btb_we_o(upd_btb_we_o),
        .upd_pht_idx_o(upd_pht_idx_o), .upd_pht_ctr_o(upd_pht_ctr_o),
        .upd_btb_idx_o(upd_btb_idx_o), .upd_btb_tag_o(upd_btb_tag_o),
        .upd_btb_target_o(upd_btb_target_o),
        .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    typedef struct {
        bit          pht_we;
        bit          btb_we;
        logic [31:0] pht_idx;
        logic [31:0] pht_ctr;
        logic [31:0] btb_idx;
        logic [31:0] btb_tag;
        logic [31:0] btb_target;
    } exp_rec_t;

    exp_rec_t    q[$];
    int unsigned m_bcnt, m_mcnt;
    int          total = 0;
    int          bad   = 0;

    bit       e_accept, e_push, e_pop, e_flush;
    exp_rec_t e_rec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Evaluates the reference rules for the current inputs and compares every output.
    task automatic check_cycle();
        bit          tk, pred, mis, rdy, valid_t;
        logic [31:0] tg, exp_b, exp_m;
        int          t, c, nc;
        t = int'(branch_type_i);
        c = int'(pht_ctr_i);
        case (t)
            1: tk = rj_value_i == rkd_value_i;
            2: tk = rj_value_i != rkd_value_i;
            3: tk = $signed(rj_value_i) <  $signed(rkd_value_i);
            4: tk = $signed(rj_value_i) >= $signed(rkd_value_i);
            5: tk = rj_value_i <  rkd_value_i;
            6: tk = rj_value_i >= rkd_value_i;
            7, 8, 9: tk = 1'b1;
            default: tk = 1'b0;
        endcase
        tg       = (t == 9) ? rj_value_i + jirl_offs_i : br_b_target_i;
        valid_t  = (t >= 1) && (t <= 9);
        rdy      = (q.size() < QDEPTH) || (q.size() != 0 && upd_ready_i);
        e_accept = branch_valid_i && rdy && valid_t;
        pred     = predict_taken_i && btb_hit_i;
        mis      = (tk != pred) || (tk && pred && tg != predict_target_i);
        e_flush  = e_accept && mis;
        nc       = tk ? ((c + 1 > MAXC) ? MAXC : c + 1) : ((c == 0) ? 0 : c - 1);
        e_rec.pht_we     = (t >= 1) && (t <= 6);
        e_rec.btb_we     = tk && (!btb_hit_i || !predict_taken_i || tg != predict_target_i);
        e_rec.pht_idx    = (pc_i >> 2) & ((32'd1 << PHT_IDX_W) - 1);
        e_rec.pht_ctr    = nc;
        e_rec.btb_idx    = (pc_i >> 2) & ((32'd1 << BTB_IDX_W) - 1);
        e_rec.btb_tag    = (pc_i >> (2 + BTB_IDX_W)) & ((32'd1 << BTB_TAG_W) - 1);
        e_rec.btb_target = tg;
        e_push = e_accept && (e_rec.pht_we || e_rec.btb_we);
        e_pop  = (q.size() != 0) && upd_ready_i;

        chk("ready", branch_ready_o, rdy);
        chk("taken", branch_taken_o, tk);
        chk("target", branch_target_o, tg);
        chk("flush", branch_flush_o, e_flush);
        chk("flush_pc", branch_flush_pc_o, tk ? tg : pc_i + 32'd4);
        chk("upd_valid", upd_valid_o, q.size() != 0);
        if (q.size() != 0) begin
            chk("head_pht_we", upd_pht_we_o, q[0].pht_we);
            chk("head_btb_we", upd_btb_we_o, q[0].btb_we);
            if (q[0].pht_we) begin
                chk("head_pht_idx", upd_pht_idx_o, q[0].pht_idx);
                chk("head_pht_ctr", upd_pht_ctr_o, q[0].pht_ctr);
            end
            if (q[0].btb_we) begin
                chk("head_btb_idx", upd_btb_idx_o, q[0].btb_idx);
                chk("head_btb_tag", upd_btb_tag_o, q[0].btb_tag);
                chk("head_btb_target", upd_btb_target_o, q[0].btb_target);
            end
        end else begin
            chk("empty_fields", {upd_pht_we_o, upd_btb_we_o, upd_pht_idx_o, upd_pht_ctr_o,
                                 upd_btb_idx_o} | upd_btb_tag_o | upd_btb_target_o, 32'd0);
        end
`ifdef BR_STATS_EN
        exp_b = m_bcnt;
        exp_m = m_mcnt;
`else
        exp_b = 32'd0;
        exp_m = 32'd0;
`endif
        chk("branch_cnt", branch_cnt_o, exp_b);
        chk("mispred_cnt", mispred_cnt_o, exp_m);
    endtask

    task automatic apply_model();
        if (e_pop) void'(q.pop_front());
        if (e_push) q.push_back(e_rec);
        if (e_accept && m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
        if (e_flush && m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic advance();
        check_cycle();
        @(posedge clk);
        apply_model();
        #1;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic drive(input int t, input logic [31:0] rj, input logic [31:0] rkd,
                         input logic [31:0] pc, input logic [31:0] bt, input logic [31:0] offs,
                         input int ctr, input bit hit, input bit pt, input logic [31:0] ptg);
        branch_valid_i   = 1'b1;
        branch_type_i    = 4'(t);
        rj_value_i       = rj;
        rkd_value_i      = rkd;
        pc_i             = pc;
        br_b_target_i    = bt;
        jirl_offs_i      = offs;
        pht_ctr_i        = CTR_W'(ctr);
        btb_hit_i        = hit;
        predict_taken_i  = pt;
        predict_target_i = ptg;
    endtask

    task automatic drain();
        branch_valid_i = 1'b0;
        upd_ready_i    = 1'b1;
        for (int i = 0; i < QDEPTH + 2; i++) step();
        chk("drained", upd_valid_o, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        branch_valid_i = 1'b0;
        upd_ready_i    = 1'b0;
        m_bcnt = 0;
        m_mcnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_upd_valid", upd_valid_o, 1'b0);
        chk("rst_ready", branch_ready_o, 1'b1);
        chk("rst_branch_cnt", branch_cnt_o, 32'd0);
        chk("rst_mispred_cnt", mispred_cnt_o, 32'd0);
        reset = 1'b1;

        // BEQ taken, predicted not-taken
        drive(1, 5, 5, 32'h1C00_0100, 32'h1C00_0200, 0, 1, 0, 0, 0);
        settle();
        chk("beq_flush", branch_flush_o, 1'b1);
        chk("beq_flush_pc", branch_flush_pc_o, 32'h1C00_0200);
        advance();
        branch_valid_i = 1'b0;
        chk("beq_valid", upd_valid_o, 1'b1);
        chk("beq_pht_ctr", upd_pht_ctr_o, 32'd2);
        chk("beq_btb_we", upd_btb_we_o, 1'b1);
        chk("beq_pht_idx", upd_pht_idx_o, 32'h040);
        chk("beq_btb_tag", upd_btb_tag_o, 32'h0E0000);
        drain();

        // BLTU not taken, counter saturates low
        upd_ready_i = 1'b0;
        drive(5, 32'hFFFF_FFFF, 1, 32'h1C00_0300, 32'h1C00_0400, 0, 0, 0, 0, 0);
        settle();
        chk("bltu_taken", branch_taken_o, 1'b0);
        chk("bltu_flush", branch_flush_o, 1'b0);
        chk("bltu_flush_pc", branch_flush_pc_o, 32'h1C00_0304);
        advance();
        branch_valid_i = 1'b0;
        chk("bltu_pht_ctr", upd_pht_ctr_o, 32'd0);
        chk("bltu_btb_we", upd_btb_we_o, 1'b0);
        chk("bltu_pht_we", upd_pht_we_o, 1'b1);
        drain();

        // JIRL predicted taken to the wrong target
        upd_ready_i = 1'b0;
        drive(9, 32'h1000, 0, 32'h1C00_0500, 32'h1C00_0600, 32'h10, 2, 1, 1, 32'h2000);
        settle();
        chk("jirl_target", branch_target_o, 32'h1010);
        chk("jirl_flush", branch_flush_o, 1'b1);
        chk("jirl_flush_pc", branch_flush_pc_o, 32'h1010);
        advance();
        branch_valid_i = 1'b0;
        chk("jirl_btb_we", upd_btb_we_o, 1'b1);
        chk("jirl_pht_we", upd_pht_we_o, 1'b0);
        chk("jirl_btb_target", upd_btb_target_o, 32'h1010);
        drain();

        // Fill the queue, then push and pop in the same cycle
        upd_ready_i = 1'b0;
        for (int i = 1; i <= QDEPTH; i++) begin
            drive(7, 0, 0, 32'h1C00_1000 + 32'(i * 4), 32'(i * 32'h100), 0, 0, 0, 0, 0);
            step();
        end
        drive(7, 0, 0, 32'h1C00_1014, 32'h500, 0, 0, 0, 0, 0);
        settle();
        chk("full_ready", branch_ready_o, 1'b0);
        chk("full_flush", branch_flush_o, 1'b0);
        advance();
        upd_ready_i = 1'b1;
        settle();
        chk("full_pop_ready", branch_ready_o, 1'b1);
        chk("full_pop_flush", branch_flush_o, 1'b1);
        advance();
        branch_valid_i = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            chk("fifo_order", upd_btb_target_o, 32'(k * 32'h100));
            step();
        end
        chk("fifo_empty", upd_valid_o, 1'b0);

        // Reset while entries are queued
        upd_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(8, 0, 0, 32'h1C00_2000 + 32'(i * 4), 32'h3000 + 32'(i), 0, 0, 0, 0, 0);
            step();
        end
        branch_valid_i = 1'b0;
        chk("pre_rst_valid", upd_valid_o, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", upd_valid_o, 1'b0);
        chk("mid_rst_branch_cnt", branch_cnt_o, 32'd0);
        chk("mid_rst_mispred_cnt", mispred_cnt_o, 32'd0);
        q.delete();
        m_bcnt = 0;
        m_mcnt = 0;
        @(posedge clk);
        #2;
        reset = 1'b1;

        // Ten accepted branches, three mispredicted
        upd_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 1)
                drive(7, 0, 0, 32'h1C00_3000 + 32'(i * 4), 32'h4000, 0, 0, 0, 0, 0);
            else
                drive(7, 0, 0, 32'h1C00_3000 + 32'(i * 4), 32'h4000, 0, 0, 1, 1, 32'h4000);
            step();
        end
        branch_valid_i = 1'b0;
`ifdef BR_STATS_EN
        chk("stat_branch_cnt", branch_cnt_o, 32'd10);
        chk("stat_mispred_cnt", mispred_cnt_o, 32'd3);
`else
        chk("stat_branch_cnt", branch_cnt_o, 32'd0);
        chk("stat_mispred_cnt", mispred_cnt_o, 32'd0);
`endif
        drain();

        // Randomized traffic with varying drain pressure
        for (int n = 0; n < 2000; n++) begin
            int          t, bias;
            logic [31:0] rj, rkd, bt, offs, tg;
            bias = (n / 64) % 3;
            t    = $urandom_range(0, 11);
            rj   = $urandom();
            rkd  = ($urandom_range(0, 3) == 0) ? rj : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8)) : $urandom());
            bt   = $urandom() & ~32'h3;
            offs = $urandom_range(0, 255) << 2;
            tg   = (t == 9) ? rj + offs : bt;
            drive(t, rj, rkd, $urandom() & ~32'h3, bt, offs, $urandom_range(0, MAXC),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 1) == 0) ? tg : tg ^ 32'h40);
            branch_valid_i = $urandom_range(0, 4) != 0;
            upd_ready_i    = (bias == 0) ? 1'b1 : (bias == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
            step();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
